// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over one raster-ordered channel, two internal line buffers.
// Build option: define CONV3X3_RELU_EN to clamp negative saturated results to zero.
module conv3x3_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 224,
    parameter int unsigned IMG_H  = 224,
    parameter int unsigned PAD    = 1,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [9*DATA_W-1:0] weight_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                valid_o,
    output logic                chnl_done
);

    localparam int unsigned CW   = $clog2(IMG_W + 2);
    localparam int unsigned RW   = $clog2(IMG_H + 2);
    localparam int unsigned LbAw = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned PW   = 2 * DATA_W;
    localparam int unsigned AccW = 2 * DATA_W + 4;

    localparam logic [CW-1:0] ColLast    = CW'(IMG_W + PAD - 1);
    localparam logic [CW-1:0] ColPad     = CW'(IMG_W);
    localparam logic [CW-1:0] ColImgLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast    = RW'(IMG_H + PAD - 1);
    localparam logic [RW-1:0] RowImgLast = RW'(IMG_H - 1);

    localparam logic signed [AccW:0] Rnd    = ((AccW + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [AccW:0] SatMax = (AccW + 1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [AccW:0] SatMin = -SatMax - (AccW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StRowPad, StBotPad} state_e;

    state_e                   state_q, state_d;
    logic                     ready_en_q;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [9*DATA_W-1:0]      weight_q, w_eff;
    logic                     xfer, step, emit, frame_end, in_img;
    logic signed [DATA_W-1:0] pix;
    logic [LbAw-1:0]          lb_idx;

    logic signed [DATA_W-1:0] lb_top_q [IMG_W];
    logic signed [DATA_W-1:0] lb_mid_q [IMG_W];
    logic signed [DATA_W-1:0] win_q    [3][2];
    logic signed [DATA_W-1:0] col_new  [3];
    logic signed [DATA_W-1:0] tap      [9];

    logic signed [PW-1:0]     prod_q [9];
    logic signed [AccW-1:0]   sum_d, sum_q;
    logic signed [AccW:0]     rnd, shr;
    logic [DATA_W-1:0]        data_d;
    logic                     v1_q, last1_q, v2_q, last2_q;

    assign ready_o   = ready_en_q && (state_q == StIdle || state_q == StRun);
    assign xfer      = valid_i && ready_o;
    assign step      = xfer || state_q == StRowPad || state_q == StBotPad;
    assign pix       = xfer ? $signed(data_i) : '0;
    assign frame_end = (row_q == RowLast) && (col_q == ColLast);
    assign in_img    = col_q < ColPad;
    assign lb_idx    = in_img ? col_q[LbAw-1:0] : '0;
    assign w_eff     = (state_q == StIdle) ? weight_i : weight_q;
    assign emit      = (PAD != 0) ? (row_q != '0 && col_q != '0)
                                  : (row_q >= RW'(2) && col_q >= CW'(2));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRun: begin
                if (xfer) begin
                    state_d = StRun;
                    if (col_q == ColImgLast) begin
                        if (PAD != 0) begin
                            state_d = StRowPad;
                        end else if (row_q == RowImgLast) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StRowPad: state_d = (row_q == RowImgLast) ? StBotPad : StRun;
            StBotPad: begin
                if (col_q == ColPad) state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (step) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Newest window column: two buffered rows above plus the current pixel; pad column is zero.
    always_comb begin
        col_new[0] = in_img ? lb_top_q[lb_idx] : '0;
        col_new[1] = in_img ? lb_mid_q[lb_idx] : '0;
        col_new[2] = pix;
        for (int ky = 0; ky < 3; ky++) begin
            tap[3*ky]   = win_q[ky][0];
            tap[3*ky+1] = win_q[ky][1];
            tap[3*ky+2] = col_new[ky];
        end
        // Taps above row 0 or left of column 0 hold stale data from earlier rows/channels.
        if (row_q < RW'(2)) begin
            tap[0] = '0;
            tap[1] = '0;
            tap[2] = '0;
        end
        if (col_q < CW'(2)) begin
            tap[0] = '0;
            tap[3] = '0;
            tap[6] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            weight_q   <= '0;
            for (int ky = 0; ky < 3; ky++) begin
                win_q[ky][0] <= '0;
                win_q[ky][1] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            col_q      <= col_d;
            row_q      <= row_d;
            if (state_q == StIdle && xfer) weight_q <= weight_i;
            if (step) begin
                for (int ky = 0; ky < 3; ky++) begin
                    win_q[ky][0] <= win_q[ky][1];
                    win_q[ky][1] <= col_new[ky];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step && in_img) begin
            lb_top_q[lb_idx] <= lb_mid_q[lb_idx];
            lb_mid_q[lb_idx] <= pix;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) sum_d = sum_d + AccW'(prod_q[k]);
    end

    always_comb begin
        rnd = (AccW + 1)'(sum_q) + Rnd;
        shr = rnd >>> SHIFT;
        if (shr > SatMax) begin
            data_d = SatMax[DATA_W-1:0];
        end else if (shr < SatMin) begin
            data_d = SatMin[DATA_W-1:0];
        end else begin
            data_d = shr[DATA_W-1:0];
        end
`ifdef CONV3X3_RELU_EN
        if (data_d[DATA_W-1]) data_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) prod_q[k] <= '0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            sum_q     <= '0;
            v2_q      <= 1'b0;
            last2_q   <= 1'b0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            chnl_done <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                prod_q[k] <= PW'(tap[k]) * PW'($signed(w_eff[k*DATA_W +: DATA_W]));
            end
            v1_q      <= step && emit;
            last1_q   <= step && frame_end;
            sum_q     <= sum_d;
            v2_q      <= v1_q;
            last2_q   <= last1_q;
            data_o    <= data_d;
            valid_o   <= v2_q;
            chnl_done <= last2_q;
        end
    end

endmodule
